pwm_carrier_shadow: RTL and testbench

Parametrised PWM carrier generator, next generation of the MLBX 16-bit timer. It provides a configurable-width up, down or up-down counter. Period, count mode and sync mask are double-buffered behind a shadow register and transferred at a selectable carrier boundary. It adds an external phase-sync input for multi-carrier alignment and registered zero/max event pulses that feed the PWM comparators and the interrupt logic.

---
 rtl/pwm_carrier_shadow.sv | 87 ++++++++
 tb/tb_pwm_carrier_shadow.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_shadow.sv
// pwm_carrier_shadow: double-buffered up/down/up-down PWM carrier with phase sync and event pulses
module pwm_carrier_shadow #(
  parameter int PWMWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                wr_en,
  input  logic [PWMWIDTH-1:0] countmax,
  input  logic [1:0]          count_mode,
  input  logic [1:0]          syncmode,
  input  logic [1:0]          upd_mode,
  input  logic                sync_in,
  input  logic [PWMWIDTH-1:0] phase,
  input  logic                phase_dir,
  output logic [PWMWIDTH-1:0] carrier,
  output logic                dir,
  output logic                sync,
  output logic                upd_done,
  output logic                pending
);
  localparam logic [PWMWIDTH-1:0] one = PWMWIDTH'(1);
  logic [PWMWIDTH-1:0] sh_max, cmax, nc;
  logic [1:0] sh_mode, sh_sync, mode, smask;
  logic stopped, at_zero, at_max, xfer, nd;
  assign stopped = mode == 2'b00 || cmax == '0;
  assign at_zero = carrier == '0;
  assign at_max = carrier == cmax;
  assign xfer = pending && (upd_mode == 2'b00 || (ce && ((upd_mode[0] && at_zero) || (upd_mode[1] && at_max))));
  // cmax - one is only reached when not stopped, so cmax >= 1 there
  always_comb begin
    nc = carrier;
    nd = dir;
    if (stopped) begin
      nc = '0;
      nd = 1'b0;
    end else if (ce) begin
      if (sync_in) begin
        nc = phase > cmax ? cmax : phase;
        nd = mode == 2'b11 ? phase_dir : mode == 2'b10;
      end else if (mode == 2'b01) begin
        nc = carrier >= cmax ? '0 : carrier + one;
        nd = 1'b0;
      end else if (mode == 2'b10) begin
        nc = (at_zero || carrier > cmax) ? cmax : carrier - one;
        nd = 1'b1;
      end else if (!dir) begin
        nc = carrier >= cmax ? cmax - one : carrier + one;
        nd = carrier >= cmax;
      end else begin
        nc = at_zero ? one : carrier - one;
        nd = !at_zero;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_max <= '0;
      sh_mode <= '0;
      sh_sync <= '0;
      cmax <= '0;
      mode <= '0;
      smask <= '0;
      carrier <= '0;
      dir <= 1'b0;
      sync <= 1'b0;
      upd_done <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (wr_en) begin
        sh_max <= countmax;
        sh_mode <= count_mode;
        sh_sync <= syncmode;
      end
      if (xfer) begin
        cmax <= sh_max;
        mode <= sh_mode;
        smask <= sh_sync;
      end
      pending <= wr_en || (pending && !xfer);
      upd_done <= xfer;
      carrier <= nc;
      dir <= nd;
      sync <= ce && !stopped && ((at_zero && smask[0]) || (at_max && smask[1]));
    end
  end
endmodule

// File: tb/tb_pwm_carrier_shadow.sv
// tb_pwm_carrier_shadow: scoreboard bench; stimulus queues hand-computed per-cycle expectations, monitor checks them
module tb_pwm_carrier_shadow;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, wr_en = 1'b0, sync_in = 1'b0, phase_dir = 1'b0;
  logic [15:0] countmax = '0, phase = '0;
  logic [1:0] count_mode = '0, syncmode = '0, upd_mode = '0;
  logic [15:0] carrier;
  logic dir, sync, upd_done, pending;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {
    int cyc;
    string nm;
    int c, d, s, u, p;
  } exp_t;
  exp_t q[$];

  pwm_carrier_shadow #(.PWMWIDTH(16)) dut (
    .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .countmax(countmax),
    .count_mode(count_mode), .syncmode(syncmode), .upd_mode(upd_mode),
    .sync_in(sync_in), .phase(phase), .phase_dir(phase_dir),
    .carrier(carrier), .dir(dir), .sync(sync), .upd_done(upd_done), .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (e.cyc != cyc || e.c != int'(carrier) || e.d != int'(dir) || e.s != int'(sync) ||
          e.u != int'(upd_done) || e.p != int'(pending)) begin
        fails++;
        $display("FAIL %s cyc=%0d/%0d got c=%0d d=%0d s=%0d u=%0d p=%0d want c=%0d d=%0d s=%0d u=%0d p=%0d",
                 e.nm, cyc, e.cyc, carrier, dir, sync, upd_done, pending, e.c, e.d, e.s, e.u, e.p);
      end
    end
  end

  // expectation is the state after the coming rising edge; pulses drop afterwards
  task automatic step(input string nm, input int c, input int d, input int s, input int u, input int p);
    exp_t e;
    e.cyc = cyc + 1;
    e.nm = nm;
    e.c = c; e.d = d; e.s = s; e.u = u; e.p = p;
    q.push_back(e);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic wr(input logic [15:0] m, input logic [1:0] md, input logic [1:0] sm);
    wr_en = 1'b1;
    countmax = m;
    count_mode = md;
    syncmode = sm;
  endtask

  task automatic psync(input logic [15:0] ph, input logic pd);
    sync_in = 1'b1;
    phase = ph;
    phase_dir = pd;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step("rst0", 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 0);
    rst = 1'b0;
    ce = 1'b1;
    upd_mode = 2'b00;
    // up mode, period 5
    wr(4, 2'b01, 2'b01);
    step("up_wr", 0, 0, 0, 0, 1);
    step("up_xfer", 0, 0, 0, 1, 0);
    step("up_1", 1, 0, 1, 0, 0);
    step("up_2", 2, 0, 0, 0, 0);
    step("up_3", 3, 0, 0, 0, 0);
    step("up_4", 4, 0, 0, 0, 0);
    step("up_0", 0, 0, 0, 0, 0);
    step("up_1b", 1, 0, 1, 0, 0);
    // up-down cmax=3, sync at both ends
    wr(3, 2'b11, 2'b11);
    step("ud_wr", 2, 0, 0, 0, 1);
    step("ud_xfer", 3, 0, 0, 1, 0);
    step("ud_2dn", 2, 1, 1, 0, 0);
    step("ud_1dn", 1, 1, 0, 0, 0);
    step("ud_0dn", 0, 1, 0, 0, 0);
    step("ud_1up", 1, 0, 1, 0, 0);
    step("ud_2up", 2, 0, 0, 0, 0);
    step("ud_3up", 3, 0, 0, 0, 0);
    step("ud_2dn_b", 2, 1, 1, 0, 0);
    // up-down cmax=8, then shadowed period change at zero
    wr(8, 2'b11, 2'b00);
    step("sh_wr8", 1, 1, 0, 0, 1);
    step("sh_xfer8", 0, 1, 0, 1, 0);
    upd_mode = 2'b01;
    step("sh_1", 1, 0, 0, 0, 0);
    step("sh_2", 2, 0, 0, 0, 0);
    step("sh_3", 3, 0, 0, 0, 0);
    step("sh_4", 4, 0, 0, 0, 0);
    step("sh_5", 5, 0, 0, 0, 0);
    wr(4, 2'b11, 2'b01);
    step("sh_wr4", 6, 0, 0, 0, 1);
    step("sh_7", 7, 0, 0, 0, 1);
    step("sh_8", 8, 0, 0, 0, 1);
    step("sh_7d", 7, 1, 0, 0, 1);
    step("sh_6d", 6, 1, 0, 0, 1);
    step("sh_5d", 5, 1, 0, 0, 1);
    step("sh_4d", 4, 1, 0, 0, 1);
    step("sh_3d", 3, 1, 0, 0, 1);
    step("sh_2d", 2, 1, 0, 0, 1);
    step("sh_1d", 1, 1, 0, 0, 1);
    step("sh_0d", 0, 1, 0, 0, 1);
    step("sh_xfer4", 1, 0, 0, 1, 0);
    step("sh_n2", 2, 0, 0, 0, 0);
    step("sh_n3", 3, 0, 0, 0, 0);
    step("sh_peak", 4, 0, 0, 0, 0);
    step("sh_n3d", 3, 1, 0, 0, 0);
    step("sh_n2d", 2, 1, 0, 0, 0);
    step("sh_n1d", 1, 1, 0, 0, 0);
    step("sh_n0d", 0, 1, 0, 0, 0);
    step("sh_n1", 1, 0, 1, 0, 0);
    // phase sync, up-down cmax=10
    upd_mode = 2'b00;
    wr(10, 2'b11, 2'b00);
    step("ph_wr", 2, 0, 0, 0, 1);
    step("ph_xfer", 3, 0, 0, 1, 0);
    psync(7, 1'b1);
    step("ph_7", 7, 1, 0, 0, 0);
    step("ph_6", 6, 1, 0, 0, 0);
    step("ph_5", 5, 1, 0, 0, 0);
    psync(20, 1'b0);
    step("ph_clamp", 10, 0, 0, 0, 0);
    step("ph_turn", 9, 1, 0, 0, 0);
    // ce gating, up mode cmax=2, carrier above new top wraps
    wr(2, 2'b01, 2'b01);
    step("ce_wr", 8, 1, 0, 0, 1);
    step("ce_xfer", 7, 1, 0, 1, 0);
    step("ce_wrap", 0, 0, 0, 0, 0);
    ce = 1'b0;
    psync(1, 1'b0);
    step("ce_off_sync", 0, 0, 0, 0, 0);
    ce = 1'b1;
    step("ce_on1", 1, 0, 1, 0, 0);
    ce = 1'b0;
    step("ce_off1", 1, 0, 0, 0, 0);
    ce = 1'b1;
    step("ce_on2", 2, 0, 0, 0, 0);
    ce = 1'b0;
    step("ce_off2", 2, 0, 0, 0, 0);
    ce = 1'b1;
    step("ce_on0", 0, 0, 0, 0, 0);
    ce = 1'b0;
    step("ce_off0", 0, 0, 0, 0, 0);
    ce = 1'b1;
    step("ce_on1b", 1, 0, 1, 0, 0);
    // run up to 5 then stop
    wr(8, 2'b01, 2'b00);
    step("st_wr", 2, 0, 0, 0, 1);
    step("st_xfer", 0, 0, 0, 1, 0);
    step("st_1", 1, 0, 0, 0, 0);
    step("st_2", 2, 0, 0, 0, 0);
    step("st_3", 3, 0, 0, 0, 0);
    step("st_4", 4, 0, 0, 0, 0);
    step("st_5", 5, 0, 0, 0, 0);
    wr(8, 2'b00, 2'b00);
    step("st_wrstop", 6, 0, 0, 0, 1);
    step("st_xferstop", 7, 0, 0, 1, 0);
    step("st_zero", 0, 0, 0, 0, 0);
    ce = 1'b0;
    step("st_zero_noce", 0, 0, 0, 0, 0);
    ce = 1'b1;
    psync(3, 1'b0);
    step("st_sync_ign", 0, 0, 0, 0, 0);
    // pending write discarded by reset
    upd_mode = 2'b10;
    wr(4, 2'b01, 2'b01);
    step("rp_wr", 0, 0, 0, 0, 1);
    step("rp_hold", 0, 0, 0, 0, 1);
    rst = 1'b1;
    wr(5, 2'b01, 2'b01);
    step("rp_rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    upd_mode = 2'b00;
    step("rp_idle1", 0, 0, 0, 0, 0);
    step("rp_idle2", 0, 0, 0, 0, 0);
    step("rp_idle3", 0, 0, 0, 0, 0);
    // down mode, period 4
    wr(3, 2'b10, 2'b11);
    step("dn_wr", 0, 0, 0, 0, 1);
    step("dn_xfer", 0, 0, 0, 1, 0);
    step("dn_3", 3, 1, 1, 0, 0);
    step("dn_2", 2, 1, 1, 0, 0);
    step("dn_1", 1, 1, 0, 0, 0);
    step("dn_0", 0, 1, 0, 0, 0);
    step("dn_3b", 3, 1, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
